fetch_unit: RTL

Instruction fetch stage for the 16-bit core, directly upstream of the instruction decoder and control unit. It owns the PC, runs a req/ack handshake to instruction memory, and presents one instruction at a time, with its PC and PC+2, through a valid/ready output register. Downstream logic redirects it on taken branches and jumps. It stops fetching on a HALT opcode.

---
 rtl/fetch_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, fetches over a req/ack port and presents one instruction at a time with its PC and PC+2.
// Zero-wait memory gives one instruction per cycle (N wait states: one per N+1); backpressure on instr_ready holds the output and stops requests.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        instr_valid,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic [15:0] instr_pc_inc,
    input  logic        instr_ready,
    output logic        halted
);

    typedef enum logic [1:0] {RUN, BUSY, STOP, HALTED} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_pc;
    logic [15:0] r_kill_addr;
    logic [15:0] r_instr;
    logic [15:0] r_instr_pc;
    logic [15:0] r_instr_pc_inc;
    logic        r_kill;
    logic        r_instr_valid;
    logic        r_halted;
    logic        w_fire;
    logic        w_pending;
    logic        w_consume;
    logic        w_is_halt;
    logic        w_capture;

    assign imem_req  = ((r_state == RUN) && (!r_instr_valid || instr_ready)) || (r_state == BUSY);
    // A killed request keeps presenting its original address until it is acked.
    assign imem_addr = r_kill ? r_kill_addr : r_pc;

    assign w_fire    = imem_req && imem_ack;
    assign w_pending = imem_req && !imem_ack;
    assign w_consume = r_instr_valid && instr_ready;
    assign w_is_halt = (imem_rdata[15:11] == 5'b00000);
    assign w_capture = w_fire && !r_kill && !redirect;

    assign instr_valid  = r_instr_valid;
    assign instr        = r_instr;
    assign instr_pc     = r_instr_pc;
    assign instr_pc_inc = r_instr_pc_inc;
    assign halted       = r_halted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= RUN;
            r_halted <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt == HALTED) begin
                r_halted <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state != HALTED) begin
            if (redirect) begin
                w_state_nxt = w_pending ? BUSY : RUN;
            end else if (w_fire) begin
                w_state_nxt = (!r_kill && w_is_halt) ? STOP : RUN;
            end else if ((r_state == RUN) && imem_req) begin
                w_state_nxt = BUSY;
            end else if ((r_state == STOP) && w_consume) begin
                w_state_nxt = HALTED;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc           <= RESET_PC;
            r_kill_addr    <= RESET_PC;
            r_kill         <= 1'b0;
            r_instr_valid  <= 1'b0;
            r_instr        <= 16'h0800;
            r_instr_pc     <= RESET_PC;
            r_instr_pc_inc <= 16'(RESET_PC + 16'd2);
        end else if (r_state != HALTED) begin
            if (redirect) begin
                r_pc          <= redirect_pc;
                r_instr_valid <= 1'b0;
                r_kill        <= w_pending;
                if (w_pending && !r_kill) begin
                    r_kill_addr <= r_pc;
                end
            end else begin
                if (w_consume) begin
                    r_instr_valid <= 1'b0;
                end
                if (w_fire && r_kill) begin
                    r_kill <= 1'b0;
                end
                if (w_capture) begin
                    r_instr        <= imem_rdata;
                    r_instr_pc     <= r_pc;
                    r_instr_pc_inc <= r_pc + 16'd2;
                    r_instr_valid  <= 1'b1;
                    r_pc           <= r_pc + 16'd2;
                end
            end
        end
    end

endmodule
